// File: rtl/cail_param_ctrl.sv
// Calibration-parameter RAM controller: clears the RAM after reset, then
// shares it between a host write/read port and an in-order dump sequencer.
// Ports:
//   clock, reset                 clock, async active-high reset
//   host_wr_req/addr/data/ack    host write port, req held until ack
//   host_rd_req/addr/ack         host read request, req held until ack
//   host_rd_valid/data           host read return, RD_LAT after ack
//   dump_start/busy/valid        dump control and streamed word strobe
//   dump_addr/data/done          dumped word; done marks the last word
//   init_done                    RAM cleared, host port live
//   ram_data/wraddress/wren      RAM write port
//   ram_rdaddress/ram_q          RAM read port
module cail_param_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter int DW = 8,
  parameter int RD_LAT = 2,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          host_wr_req,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [DW-1:0] host_wr_data,
  output logic          host_wr_ack,
  input  logic          host_rd_req,
  input  logic [AW-1:0] host_rd_addr,
  output logic          host_rd_ack,
  output logic          host_rd_valid,
  output logic [DW-1:0] host_rd_data,
  input  logic          dump_start,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          dump_done,
  output logic          init_done,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_wraddress,
  output logic          ram_wren,
  output logic [AW-1:0] ram_rdaddress,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_DUMP = 2'd2
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e state_q, state_d;

  logic [AW-1:0] init_cnt_q, init_cnt_d;
  // One extra bit so "all DEPTH words issued" is visible.
  logic [AW:0]   iss_q, iss_d;
  logic [AW-1:0] rdaddr_q, rdaddr_d;

  // Read-tag pipeline, one stage per clock of RAM read latency.
  logic [RD_LAT-1:0] tv_q;
  logic [RD_LAT-1:0] th_q;
  logic [AW-1:0]     ta_q [RD_LAT];

  logic [DW-1:0] hdata_q;
  logic [AW-1:0] daddr_q;
  logic [DW-1:0] ddata_q;

  logic          live;
  logic          wr_ack;
  logic          rd_ack;
  logic          dump_iss;
  logic [AW-1:0] dptr;
  logic          out_v;
  logic          out_h;
  logic [AW-1:0] out_a;

  assign live   = (state_q != S_INIT);
  assign wr_ack = live & host_wr_req;

  // A read hitting this cycle's write waits one cycle so it sees new data.
  assign rd_ack = live & host_rd_req
                & ~(wr_ack & (host_wr_addr == host_rd_addr));

  assign dptr = iss_q[AW-1:0];

  assign dump_iss = (state_q == S_DUMP) & ~iss_q[AW] & ~rd_ack
                  & ~(wr_ack & (host_wr_addr == dptr));

  always_comb begin
    rdaddr_d = rdaddr_q;
    if (rd_ack) begin
      rdaddr_d = host_rd_addr;
    end else if (dump_iss) begin
      rdaddr_d = dptr;
    end
  end

  assign out_v = tv_q[RD_LAT-1];
  assign out_h = th_q[RD_LAT-1];
  assign out_a = ta_q[RD_LAT-1];

  assign host_wr_ack   = wr_ack;
  assign host_rd_ack   = rd_ack;
  assign host_rd_valid = out_v & out_h;
  assign host_rd_data  = host_rd_valid ? ram_q : hdata_q;
  assign dump_valid    = out_v & ~out_h;
  assign dump_addr     = dump_valid ? out_a : daddr_q;
  assign dump_data     = dump_valid ? ram_q : ddata_q;
  assign dump_done     = dump_valid & (out_a == LAST);
  assign dump_busy     = (state_q == S_DUMP);
  assign init_done     = live;

  // Init clearing owns the write port; wren is held low while in reset.
  assign ram_wren      = ~reset & (~live | host_wr_req);
  assign ram_wraddress = live ? host_wr_addr : init_cnt_q;
  assign ram_data      = live ? host_wr_data : INIT_VAL;
  assign ram_rdaddress = rdaddr_d;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    iss_d      = iss_q;
    unique case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == LAST) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        iss_d = '0;
        if (dump_start) begin
          state_d = S_DUMP;
        end
      end
      S_DUMP: begin
        if (dump_iss) begin
          iss_d = iss_q + (AW+1)'(1);
        end
        if (dump_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      iss_q      <= '0;
      rdaddr_q   <= '0;
      tv_q       <= '0;
      th_q       <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        ta_q[i] <= '0;
      end
      hdata_q    <= '0;
      daddr_q    <= '0;
      ddata_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      iss_q      <= iss_d;
      rdaddr_q   <= rdaddr_d;
      tv_q       <= {tv_q[RD_LAT-2:0], rd_ack | dump_iss};
      th_q       <= {th_q[RD_LAT-2:0], rd_ack};
      ta_q[0]    <= rdaddr_d;
      for (int i = 1; i < RD_LAT; i++) begin
        ta_q[i] <= ta_q[i-1];
      end
      if (host_rd_valid) begin
        hdata_q <= ram_q;
      end
      if (dump_valid) begin
        daddr_q <= out_a;
        ddata_q <= ram_q;
      end
    end
  end

endmodule

// File: doc/cail_param_ctrl.md
Name: cail_param_ctrl

Overview:
Controller for the 32x8 calibration-parameter dual-port RAM (cail_param). After reset it clears the RAM to a default value. It then shares the RAM between a host write/read port and a dump sequencer that streams every parameter, in address order, to the calibration datapath. It drives all RAM ports (data, wraddress, wren, rdaddress) and consumes q.

Parameters:
DEPTH, 32, number of parameter words (power of 2)
AW, 5, address width, log2(DEPTH)
DW, 8, data width
RD_LAT, 2, RAM read latency in clocks from rdaddress to q (address plus output register)
INIT_VAL, 8'h00, value written to every word during init

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-high
host_wr_req  in  1  write request, held until ack
host_wr_addr  in  AW  write address
host_wr_data  in  DW  write data
host_wr_ack  out  1  write accepted this cycle (combinational)
host_rd_req  in  1  read request, held until ack
host_rd_addr  in  AW  read address
host_rd_ack  out  1  read accepted this cycle (combinational)
host_rd_valid  out  1  host_rd_data valid (1-cycle pulse)
host_rd_data  out  DW  read data
dump_start  in  1  start-dump pulse
dump_busy  out  1  dump in progress
dump_valid  out  1  dump_addr/dump_data valid
dump_addr  out  AW  address of dumped word
dump_data  out  DW  dumped word
dump_done  out  1  pulse coincident with last dump_valid
init_done  out  1  RAM initialised, host port live
ram_data  out  DW  to RAM data
ram_wraddress  out  AW  to RAM wraddress
ram_wren  out  1  to RAM wren
ram_rdaddress  out  AW  to RAM rdaddress
ram_q  in  DW  from RAM q

Behaviour:
- Reset values: state INIT, init counter 0, all out flags 0, all data/address outputs 0, read-tag pipeline cleared.
- Reset asserted mid-operation aborts any dump or pending read. No valid is emitted for in-flight reads. Init restarts on reset release.
- FSM states:
  - INIT -> IDLE after address DEPTH-1 is written.
  - IDLE -> DUMP on dump_start.
  - DUMP -> IDLE in the cycle dump_done is issued.
- INIT:
  - ram_wren=1, ram_data=INIT_VAL, ram_wraddress = counter 0..DEPTH-1, one word per cycle: DEPTH cycles.
  - host_wr_ack=0, host_rd_ack=0; dump_start ignored.
  - init_done=1 from the first IDLE cycle and stays 1 until reset.
- Write port (IDLE/DUMP):
  - host_wr_ack = host_wr_req.
  - ram_wren = host_wr_ack; ram_wraddress/ram_data = host inputs.
  - Writes are never stalled by dumps.
- Read port priority, per cycle:
  1. Host read is accepted when host_rd_req and host_rd_addr != accepted write address this cycle. On a collision, ack is withheld one cycle so read data is always post-write.
  2. Otherwise a dump read issues if DUMP, issue counter < DEPTH, and the dump address does not collide with this cycle's accepted write address.
  3. Otherwise ram_rdaddress holds its previous value.
- Read-tag pipeline, RD_LAT deep, carries {valid, is_host, addr}:
  - At depth RD_LAT, is_host=1 gives host_rd_valid=1, host_rd_data=ram_q.
  - is_host=0 gives dump_valid=1, dump_addr=tag addr, dump_data=ram_q.
- Host read latency is RD_LAT cycles from ack to host_rd_valid. Back-to-back acks give back-to-back valids.
- DUMP:
  - dump_busy=1 from the cycle after dump_start until dump_done inclusive.
  - Issue counter 0..DEPTH-1 increments only on issue; words are emitted strictly in address order.
  - dump_done pulses with the valid of address DEPTH-1.
  - dump_start while DUMP or INIT is ignored.
  - dump_start in the same cycle as dump_done's return to IDLE is ignored.
- A write during DUMP to an address not yet dumped is reflected in the dump. An already-dumped address is not re-sent.
- Host data outputs hold their last value when not valid.

Test Plan:
- Reset release: ram_wren=1 for 32 consecutive cycles, addresses 0..31, data 8'h00. init_done rises on cycle 33. Any dump reads all 8'h00.
- Host writes {0:8'h11, 1:8'h22, 2:8'h33, 3:8'h44}, each acked the same cycle. Host reads 0..3 back-to-back: host_rd_valid for 4 consecutive cycles with 11,22,33,44, each 2 cycles after its ack.
- Write 8'h5A@7 and read @7 in the same cycle: write acked, read ack delayed 1 cycle, host_rd_data=8'h5A.
- dump_start after loading addr n = n+1: 32 dump_valid pulses with addr 0..31, data 01..20. dump_done coincides with addr 31. dump_busy falls afterwards.
- Host read of addr 3 every other cycle during a dump: each host read gets priority (valid 2 cycles later). Dump still delivers all 32 words in order, with dump_valid gaps where it was stalled.
- Assert reset at dump word 10: outputs clear immediately with no further dump_valid. The init sequence then repeats and RAM contents return to 8'h00.
